// File: rtl/udp_payload_gen.sv
// udp_payload_gen: trigger-driven test frame source for the packet sender.
// Emits a header word then a counting pattern per i_sync edge, with valid/ready.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   i_sync           frame trigger, rising edge starts a frame
//   i_enable         accept new triggers when 1
//   i_frame_words    frame length in 32-bit words, sampled at frame start
//   o_data/o_vld     payload word and its valid, accepted when i_rdy is high
//   o_sof/o_eof      first / last word markers, qualified by o_vld
//   o_busy           high while sending a frame or in the inter-frame gap
//   o_frame_cnt      completed frames (wrapping)
//   o_miss_cnt       dropped triggers (saturating)
module udp_payload_gen #(
   parameter int          LEN_W   = 14,
   parameter int          GAP_CYC = 16,
   parameter logic [15:0] HDR_TAG = 16'hA55A
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_sync,
   input  logic             i_enable,
   input  logic [LEN_W-1:0] i_frame_words,
   output logic [31:0]      o_data,
   output logic             o_vld,
   input  logic             i_rdy,
   output logic             o_sof,
   output logic             o_eof,
   output logic             o_busy,
   output logic [15:0]      o_frame_cnt,
   output logic [7:0]       o_miss_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;
   localparam int         GW   = $clog2(GAP_CYC + 1);

   logic [1:0]       state;
   logic             sync_d;
   logic             pending;
   logic [15:0]      seq;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] idx;
   logic [LEN_W-1:0] idx_nxt;
   logic [GW-1:0]    gap_cnt;
   logic             trig;
   logic             start;
   logic             xfer;

   assign trig    = i_sync & ~sync_d;
   assign start   = (state == IDLE) & (trig | pending) & i_enable
                  & (i_frame_words != '0);
   assign xfer    = (state == SEND) & o_vld & i_rdy;
   assign idx_nxt = idx + LEN_W'(1);
   assign o_busy  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         sync_d      <= i_sync;
         pending     <= 1'b0;
         seq         <= '0;
         len         <= '0;
         idx         <= '0;
         gap_cnt     <= '0;
         o_data      <= '0;
         o_vld       <= 1'b0;
         o_sof       <= 1'b0;
         o_eof       <= 1'b0;
         o_frame_cnt <= '0;
         o_miss_cnt  <= '0;
      end else begin
         sync_d <= i_sync;
         unique case (state)
            IDLE: begin
               // a pending trigger is either consumed here or dropped
               pending <= 1'b0;
               if (start) begin
                  state  <= SEND;
                  len    <= i_frame_words;
                  idx    <= '0;
                  o_vld  <= 1'b1;
                  o_data <= {HDR_TAG, seq};
                  o_sof  <= 1'b1;
                  o_eof  <= (i_frame_words == LEN_W'(1));
               end
            end
            SEND: begin
               if (xfer) begin
                  if (o_eof) begin
                     o_vld       <= 1'b0;
                     o_sof       <= 1'b0;
                     o_eof       <= 1'b0;
                     seq         <= seq + 16'd1;
                     o_frame_cnt <= o_frame_cnt + 16'd1;
                     gap_cnt     <= '0;
                     state       <= GAP;
                  end else begin
                     // preload the next word so back-to-back beats need no bubble
                     idx    <= idx_nxt;
                     o_data <= {seq, 16'(idx_nxt)};
                     o_sof  <= 1'b0;
                     o_eof  <= (idx_nxt == len - LEN_W'(1));
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_CYC - 1))
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt + GW'(1);
            end
            default: state <= IDLE;
         endcase

         if (state != IDLE) begin
            if (!i_enable)
               pending <= 1'b0;
            else if (trig) begin
               if (!pending)
                  pending <= 1'b1;
               else if (o_miss_cnt != 8'hFF)
                  o_miss_cnt <= o_miss_cnt + 8'd1;
            end
         end
      end
   end

endmodule
